reservation_station: RTL and testbench

- Receiving end of the decoder→RS issue interface in the Tomasulo core.
- Buffers non-load/store instructions until both operands are valid.
- Snoops the ALU and LSB CDBs to wake up waiting operands.
- Each cycle, dispatches the lowest-index ready entry to the ALU through registered outputs. Reports free-space status back to the decoder via rs_idle.

---
 rtl/reservation_station.sv | 208 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: buffers ALU-bound instructions until both operands are valid, snoops both CDBs,
// and dispatches the lowest-index ready entry through registered ex_* outputs.
module reservation_station #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    output logic              rs_idle,
    input  logic              issue_in,
    input  logic [TAG_W-1:0]  issue_dest,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_tag1,
    input  logic [DATA_W-1:0] issue_data1,
    input  logic [TAG_W-1:0]  issue_tag2,
    input  logic [DATA_W-1:0] issue_data2,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic              alu_cdb_valid,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [DATA_W-1:0] alu_cdb_data,
    input  logic              lsb_cdb_valid,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [DATA_W-1:0] lsb_cdb_data,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_v1,
    output logic [DATA_W-1:0] ex_v2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [TAG_W-1:0]  ex_dest
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [OP_W-1:0]   op_d   [DEPTH];
    logic [TAG_W-1:0]  dest_q [DEPTH];
    logic [TAG_W-1:0]  dest_d [DEPTH];
    logic [TAG_W-1:0]  q1_q   [DEPTH];
    logic [TAG_W-1:0]  q1_d   [DEPTH];
    logic [TAG_W-1:0]  q2_q   [DEPTH];
    logic [TAG_W-1:0]  q2_d   [DEPTH];
    logic [DATA_W-1:0] v1_q   [DEPTH];
    logic [DATA_W-1:0] v1_d   [DEPTH];
    logic [DATA_W-1:0] v2_q   [DEPTH];
    logic [DATA_W-1:0] v2_d   [DEPTH];
    logic [DATA_W-1:0] imm_q  [DEPTH];
    logic [DATA_W-1:0] imm_d  [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] pc_d   [DEPTH];

    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_v1_q, ex_v1_d, ex_v2_q, ex_v2_d, ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
    logic [TAG_W-1:0]  ex_dest_q, ex_dest_d;

    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              sel_found;

    // A zero CDB tag never matches, so a zero operand tag can never be hit either.
    function automatic logic hit(input logic v, input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] q);
        return v && (t != '0) && (t == q);
    endfunction

    assign rs_idle  = ~&busy_q;
    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_v1    = ex_v1_q;
    assign ex_v2    = ex_v2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_pc    = ex_pc_q;
    assign ex_dest  = ex_dest_q;

    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
            if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        dest_d     = dest_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        ex_valid_d = 1'b0;
        ex_op_d    = ex_op_q;
        ex_v1_d    = ex_v1_q;
        ex_v2_d    = ex_v2_q;
        ex_imm_d   = ex_imm_q;
        ex_pc_d    = ex_pc_q;
        ex_dest_d  = ex_dest_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i]) begin
                if (hit(alu_cdb_valid, alu_cdb_tag, q1_q[i])) begin
                    q1_d[i] = '0;
                    v1_d[i] = alu_cdb_data;
                end else if (hit(lsb_cdb_valid, lsb_cdb_tag, q1_q[i])) begin
                    q1_d[i] = '0;
                    v1_d[i] = lsb_cdb_data;
                end
                if (hit(alu_cdb_valid, alu_cdb_tag, q2_q[i])) begin
                    q2_d[i] = '0;
                    v2_d[i] = alu_cdb_data;
                end else if (hit(lsb_cdb_valid, lsb_cdb_tag, q2_q[i])) begin
                    q2_d[i] = '0;
                    v2_d[i] = lsb_cdb_data;
                end
            end
        end
        if (sel_found) begin
            busy_d[sel_idx] = 1'b0;
            ex_valid_d      = 1'b1;
            ex_op_d         = op_q[sel_idx];
            ex_v1_d         = v1_q[sel_idx];
            ex_v2_d         = v2_q[sel_idx];
            ex_imm_d        = imm_q[sel_idx];
            ex_pc_d         = pc_q[sel_idx];
            ex_dest_d       = dest_q[sel_idx];
        end
        // The free slot is never the dispatched one, so issue and dispatch cannot collide.
        if (issue_in && rs_idle && issue_op != '0) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_op;
            dest_d[free_idx] = issue_dest;
            imm_d[free_idx]  = issue_imm;
            pc_d[free_idx]   = issue_pc;
            q1_d[free_idx]   = issue_tag1;
            v1_d[free_idx]   = issue_data1;
            q2_d[free_idx]   = issue_tag2;
            v2_d[free_idx]   = issue_data2;
            if (hit(alu_cdb_valid, alu_cdb_tag, issue_tag1)) begin
                q1_d[free_idx] = '0;
                v1_d[free_idx] = alu_cdb_data;
            end else if (hit(lsb_cdb_valid, lsb_cdb_tag, issue_tag1)) begin
                q1_d[free_idx] = '0;
                v1_d[free_idx] = lsb_cdb_data;
            end
            if (hit(alu_cdb_valid, alu_cdb_tag, issue_tag2)) begin
                q2_d[free_idx] = '0;
                v2_d[free_idx] = alu_cdb_data;
            end else if (hit(lsb_cdb_valid, lsb_cdb_tag, issue_tag2)) begin
                q2_d[free_idx] = '0;
                v2_d[free_idx] = lsb_cdb_data;
            end
        end
        if (clear_in) begin
            busy_d     = '0;
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_v1_q    <= '0;
            ex_v2_q    <= '0;
            ex_imm_q   <= '0;
            ex_pc_q    <= '0;
            ex_dest_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                q1_q[i]   <= '0;
                q2_q[i]   <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                imm_q[i]  <= '0;
                pc_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_v1_q    <= ex_v1_d;
            ex_v2_q    <= ex_v2_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc_q    <= ex_pc_d;
            ex_dest_q  <= ex_dest_d;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vectors with hand-computed expectations for reservation_station.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, rs_idle, issue_in;
    logic [3:0]  issue_dest, issue_tag1, issue_tag2, alu_cdb_tag, lsb_cdb_tag, ex_dest;
    logic [5:0]  issue_op, ex_op;
    logic [31:0] issue_data1, issue_data2, issue_imm, issue_pc, alu_cdb_data, lsb_cdb_data;
    logic        alu_cdb_valid, lsb_cdb_valid, ex_valid;
    logic [31:0] ex_v1, ex_v2, ex_imm, ex_pc;
    int passed = 0;
    int total = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in), .rs_idle(rs_idle),
        .issue_in(issue_in), .issue_dest(issue_dest), .issue_op(issue_op),
        .issue_tag1(issue_tag1), .issue_data1(issue_data1), .issue_tag2(issue_tag2),
        .issue_data2(issue_data2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_dest(ex_dest)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [3:0] dest, input logic [5:0] op, input logic [3:0] t1,
                         input logic [31:0] d1, input logic [3:0] t2, input logic [31:0] d2,
                         input logic [31:0] imm);
        issue_in    = 1'b1;
        issue_dest  = dest;
        issue_op    = op;
        issue_tag1  = t1;
        issue_data1 = d1;
        issue_tag2  = t2;
        issue_data2 = d2;
        issue_imm   = imm;
        issue_pc    = 32'h1000 + {28'd0, dest};
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; issue_in = 1'b0;
        issue_dest = '0; issue_op = '0; issue_tag1 = '0; issue_tag2 = '0;
        issue_data1 = '0; issue_data2 = '0; issue_imm = '0; issue_pc = '0;
        alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_data = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
        tick(); tick();
        rst_in = 1'b0;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_op", {26'd0, ex_op}, 32'd0);
        check("rst_ex_dest", {28'd0, ex_dest}, 32'd0);
        check("rst_ex_v1", ex_v1, 32'd0);
        check("rst_idle", {31'd0, rs_idle}, 32'd1);

        // ADDI: issue cycle 1, dispatch visible in cycle 3
        issue(4'd3, 6'd1, 4'd0, 32'd5, 4'd0, 32'd7, 32'd10);
        tick();
        issue_in = 1'b0;
        check("addi_not_yet", {31'd0, ex_valid}, 32'd0);
        check("addi_idle", {31'd0, rs_idle}, 32'd1);
        tick();
        check("addi_valid", {31'd0, ex_valid}, 32'd1);
        check("addi_dest", {28'd0, ex_dest}, 32'd3);
        check("addi_v1", ex_v1, 32'd5);
        check("addi_v2", ex_v2, 32'd7);
        check("addi_imm", ex_imm, 32'd10);
        check("addi_op", {26'd0, ex_op}, 32'd1);
        check("addi_pc", ex_pc, 32'h1003);
        tick();
        check("addi_once", {31'd0, ex_valid}, 32'd0);

        // wakeup via ALU CDB
        issue(4'd2, 6'd4, 4'd5, 32'd0, 4'd0, 32'd1, 32'd0);
        tick();
        issue_in = 1'b0;
        tick();
        check("wake_wait", {31'd0, ex_valid}, 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd5; alu_cdb_data = 32'h55;
        tick();
        alu_cdb_valid = 1'b0;
        check("wake_edge", {31'd0, ex_valid}, 32'd0);
        tick();
        check("wake_valid", {31'd0, ex_valid}, 32'd1);
        check("wake_v1", ex_v1, 32'h55);
        check("wake_dest", {28'd0, ex_dest}, 32'd2);

        // same-cycle bypass from LSB CDB
        issue(4'd4, 6'd2, 4'd0, 32'd1, 4'd6, 32'd0, 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd6; lsb_cdb_data = 32'hAB;
        tick();
        issue_in = 1'b0; lsb_cdb_valid = 1'b0;
        check("byp_not_yet", {31'd0, ex_valid}, 32'd0);
        tick();
        check("byp_valid", {31'd0, ex_valid}, 32'd1);
        check("byp_v2", ex_v2, 32'hAB);
        check("byp_dest", {28'd0, ex_dest}, 32'd4);

        // fill all entries waiting on tag 9
        for (int i = 0; i < 16; i++) begin
            issue(4'(i), 6'd2, 4'd9, 32'd0, 4'd0, 32'd3, 32'd0);
            tick();
        end
        check("full_idle", {31'd0, rs_idle}, 32'd0);
        issue(4'd15, 6'd3, 4'd0, 32'h77, 4'd0, 32'd0, 32'd0);
        tick();
        issue_in = 1'b0;
        check("full_drop_idle", {31'd0, rs_idle}, 32'd0);
        check("full_drop_nodisp", {31'd0, ex_valid}, 32'd0);
        tick();
        check("full_drop_nodisp2", {31'd0, ex_valid}, 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd9; alu_cdb_data = 32'h99;
        tick();
        alu_cdb_valid = 1'b0;
        check("full_wake_edge", {31'd0, ex_valid}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("drain_valid", {31'd0, ex_valid}, 32'd1);
            check("drain_dest", {28'd0, ex_dest}, k);
            check("drain_v1", ex_v1, 32'h99);
            check("drain_op", {26'd0, ex_op}, 32'd2);
            if (k == 0) check("drain_idle", {31'd0, rs_idle}, 32'd1);
        end
        tick();
        check("drain_done", {31'd0, ex_valid}, 32'd0);

        // two ready entries flushed by clear; in-cycle issue dropped
        issue(4'd7, 6'd1, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0);
        tick();
        issue(4'd8, 6'd1, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0);
        tick();
        issue_in = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd10; alu_cdb_data = 32'hA0;
        tick();
        alu_cdb_valid = 1'b0;
        clear_in = 1'b1;
        issue(4'd9, 6'd1, 4'd0, 32'd1, 4'd0, 32'd1, 32'd0);
        tick();
        clear_in = 1'b0; issue_in = 1'b0;
        check("clr_valid", {31'd0, ex_valid}, 32'd0);
        check("clr_idle", {31'd0, rs_idle}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("clr_never", {31'd0, ex_valid}, 32'd0);
        end

        // rdy_in low stalls a ready entry
        issue(4'd11, 6'd5, 4'd0, 32'h11, 4'd0, 32'h22, 32'd0);
        tick();
        issue_in = 1'b0;
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", {31'd0, ex_valid}, 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        check("stall_valid", {31'd0, ex_valid}, 32'd1);
        check("stall_dest", {28'd0, ex_dest}, 32'd11);
        check("stall_v1", ex_v1, 32'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
